// File: rtl/mem_pkg.sv
// Shared definitions for the MAR/MDR memory-interface stage: state encoding
// and default bus widths.
package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;

    // Transaction sequencer states, encoding fixed so checkers can decode it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_reg.sv
// Parameterised-width register with load enable and asynchronous active-low
// clear. Used for both MAR and MDR.
module mem_reg
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold value unless load is asserted; clear immediately on clr_n.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR memory-interface stage sitting in front of the 512x32 ram.
// Latches address/data from the CPU bus, sequences single-cycle ram write
// strobes and multi-cycle read strobes, and captures read data into the MDR.
//
// Handshake with the control unit: rd_req/wr_req are level-sampled only in
// IDLE; the sampling edge starts a transaction, busy is high while the ram is
// being accessed, and done pulses for exactly one cycle when the result (MDR
// for reads, ram contents for writes) is in place. Requests and register loads
// presented while busy or done are ignored.
module mem_interface
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    // Wait counter only needs to hold RD_LAT-1.
    localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               in_idle;
    logic               rd_capture;
    logic               mar_load;
    logic               mdr_load;
    logic [ADDR_W-1:0]  mar_q;
    logic [DATA_W-1:0]  mdr_q;
    logic [DATA_W-1:0]  mdr_d;

    // Loads are accepted only in IDLE, so MAR stays frozen for the whole
    // transaction and ram_addr cannot move under an active strobe.
    assign in_idle    = (state == IDLE);
    assign rd_capture = (state == WAIT) && (cnt == '0);
    assign mar_load   = in_idle && mar_in;
    assign mdr_load   = (in_idle && mdr_in) || rd_capture;
    assign mdr_d      = rd_capture ? ram_data_out : bus_in;

    mem_reg #(.W(ADDR_W)) u_mar (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (mar_load),
        .d     (bus_in[ADDR_W-1:0]),
        .q     (mar_q)
    );

    mem_reg #(.W(DATA_W)) u_mdr (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (mdr_load),
        .d     (mdr_d),
        .q     (mdr_q)
    );

    assign ram_addr    = mar_q;
    assign ram_data_in = mdr_q;
    assign mdr_out     = mdr_q;

    // State register; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Read-latency counter: armed in READ, counts down through WAIT.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (state == READ) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Next-state and strobe decode; write wins when both requests arrive.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nx = WRITE;
                end else if (rd_req) begin
                    state_nx = READ;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                ram_write = 1'b1;
                state_nx  = DONE;
            end
            READ: begin
                busy     = 1'b1;
                ram_read = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                ram_read = 1'b1;
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: two instances (RD_LAT=1 and RD_LAT=3), each with
// its own ram model and a transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        clr_n  [2];
    logic [31:0] bus_in [2];
    logic        mar_in [2];
    logic        mdr_in [2];
    logic        rd_req [2];
    logic        wr_req [2];
    logic        ram_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 clk = ~clk;

    // Power-up ram contents, identical for the ram model and the reference.
    function automatic logic [31:0] init_val(input int g, input int a);
        logic [31:0] v;
        if (g == 1 && a == 511) begin
            v = 32'h1234_5678;
        end else begin
            v = (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ 32'(g);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_blk
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] mdr_out;
        logic [31:0] ram_data_in;
        logic [31:0] ram_data_out;
        logic        busy;
        logic        done;
        logic        ram_read;
        logic        ram_write;
        logic [8:0]  ram_addr;

        mem_interface #(.DATA_W(32), .ADDR_W(9), .RD_LAT(LAT)) dut (
            .clk          (clk),
            .clr_n        (clr_n[g]),
            .bus_in       (bus_in[g]),
            .mar_in       (mar_in[g]),
            .mdr_in       (mdr_in[g]),
            .rd_req       (rd_req[g]),
            .wr_req       (wr_req[g]),
            .mdr_out      (mdr_out),
            .busy         (busy),
            .done         (done),
            .ram_read     (ram_read),
            .ram_write    (ram_write),
            .ram_addr     (ram_addr),
            .ram_data_in  (ram_data_in),
            .ram_data_out (ram_data_out)
        );

        // ram model: data valid LAT edges after a read-strobe edge, junk otherwise
        logic [31:0]    ram_mem [512];
        logic [31:0]    pipe_d  [LAT];
        logic [LAT-1:0] pipe_v;
        logic [31:0]    junk;

        always @(posedge clk) begin
            junk <= $urandom;
            if (!ram_ready) begin
                for (int a = 0; a < 512; a++) ram_mem[a] <= init_val(g, a);
            end else if (ram_write) begin
                ram_mem[ram_addr] <= ram_data_in;
            end
            pipe_d[0] <= ram_mem[ram_addr];
            pipe_v[0] <= ram_read;
            for (int k = 1; k < LAT; k++) begin
                pipe_d[k] <= pipe_d[k-1];
                pipe_v[k] <= pipe_v[k-1];
            end
        end

        assign ram_data_out = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

        // Reference model: m_op 0=idle 1=write 2=read; m_t = cycle index
        // inside the transaction (write lasts 2 cycles, read LAT+2).
        logic [8:0]  m_mar;
        logic [31:0] m_mdr;
        int          m_op;
        int          m_t;
        logic [31:0] exp_mem [512];

        always @(posedge clk or negedge clr_n[g]) begin
            if (!clr_n[g]) begin
                m_mar <= '0;
                m_mdr <= '0;
                m_op  <= 0;
                m_t   <= 0;
            end else if (m_op == 0) begin
                if (mar_in[g]) m_mar <= bus_in[g][8:0];
                if (mdr_in[g]) m_mdr <= bus_in[g];
                if (wr_req[g]) begin
                    m_op <= 1;
                    m_t  <= 1;
                end else if (rd_req[g]) begin
                    m_op <= 2;
                    m_t  <= 1;
                end
            end else if (m_t == ((m_op == 1) ? 2 : LAT + 2)) begin
                m_op <= 0;
                m_t  <= 0;
            end else begin
                m_t <= m_t + 1;
                if (m_op == 2 && m_t == LAT + 1) m_mdr <= exp_mem[m_mar];
            end
        end

        always @(posedge clk) begin
            if (!ram_ready) begin
                for (int a = 0; a < 512; a++) exp_mem[a] <= init_val(g, a);
            end else if (clr_n[g] && m_op == 1 && m_t == 1) begin
                exp_mem[m_mar] <= m_mdr;
            end
        end

        // Compare every cycle on the falling edge
        always @(negedge clk) begin : cmp
            int len;
            len = (m_op == 1) ? 2 : LAT + 2;
            check($sformatf("dut%0d busy", g),        32'(busy),      32'(m_op != 0 && m_t < len));
            check($sformatf("dut%0d done", g),        32'(done),      32'(m_op != 0 && m_t == len));
            check($sformatf("dut%0d ram_write", g),   32'(ram_write), 32'(m_op == 1 && m_t == 1));
            check($sformatf("dut%0d ram_read", g),    32'(ram_read),  32'(m_op == 2 && m_t <= LAT + 1));
            check($sformatf("dut%0d ram_addr", g),    32'(ram_addr),  32'(m_mar));
            check($sformatf("dut%0d ram_data_in", g), ram_data_in,    m_mdr);
            check($sformatf("dut%0d mdr_out", g),     mdr_out,        m_mdr);
            check($sformatf("dut%0d strobe overlap", g), 32'(ram_read & ram_write), 32'd0);
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic apply(input int i, input logic [31:0] b, input logic mi, input logic di,
                         input logic rr, input logic wr);
        bus_in[i] = b;
        mar_in[i] = mi;
        mdr_in[i] = di;
        rd_req[i] = rr;
        wr_req[i] = wr;
        @(posedge clk);
        #1;
        bus_in[i] = $urandom;
        mar_in[i] = 1'b0;
        mdr_in[i] = 1'b0;
        rd_req[i] = 1'b0;
        wr_req[i] = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : main
        int k;
        logic [31:0] b;
        ram_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clr_n[i]  = 1'b0;
            bus_in[i] = '0;
            mar_in[i] = 1'b0;
            mdr_in[i] = 1'b0;
            rd_req[i] = 1'b0;
            wr_req[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("reset busy",        32'(g_blk[0].busy),      0);
        check("reset done",        32'(g_blk[0].done),      0);
        check("reset ram_read",    32'(g_blk[0].ram_read),  0);
        check("reset ram_write",   32'(g_blk[0].ram_write), 0);
        check("reset mdr_out",     g_blk[0].mdr_out,        0);
        check("reset ram_addr",    32'(g_blk[0].ram_addr),  0);
        check("reset ram_data_in", g_blk[0].ram_data_in,    0);
        ram_ready = 1'b1;
        clr_n[0]  = 1'b1;
        clr_n[1]  = 1'b1;
        step(1);

        // Write 42 to address 1
        apply(0, 32'd1, 1, 0, 0, 0);
        apply(0, 32'd42, 0, 1, 0, 0);
        apply(0, 32'd0, 0, 0, 0, 1);
        check("wr ram_write",   32'(g_blk[0].ram_write), 1);
        check("wr ram_addr",    32'(g_blk[0].ram_addr),  1);
        check("wr ram_data_in", g_blk[0].ram_data_in,    42);
        check("wr busy",        32'(g_blk[0].busy),      1);
        step(1);
        check("wr done",        32'(g_blk[0].done),      1);
        check("wr busy in done", 32'(g_blk[0].busy),     0);
        check("wr strobe width", 32'(g_blk[0].ram_write), 0);
        step(1);
        check("wr done width",  32'(g_blk[0].done),      0);

        // Read back address 1
        apply(0, 32'd0, 0, 0, 1, 0);
        check("rd ram_read c1", 32'(g_blk[0].ram_read), 1);
        check("rd ram_addr c1", 32'(g_blk[0].ram_addr), 1);
        step(1);
        check("rd ram_read c2", 32'(g_blk[0].ram_read), 1);
        check("rd early done",  32'(g_blk[0].done),     0);
        step(1);
        check("rd done",        32'(g_blk[0].done),     1);
        check("rd mdr_out",     g_blk[0].mdr_out,       42);
        check("rd strobe off",  32'(g_blk[0].ram_read), 0);
        step(1);

        // Simultaneous requests: write wins
        apply(0, 32'd5, 1, 0, 0, 0);
        apply(0, 32'hDEAD_BEEF, 0, 1, 0, 0);
        apply(0, 32'd0, 0, 0, 1, 1);
        check("both ram_write", 32'(g_blk[0].ram_write), 1);
        check("both ram_read",  32'(g_blk[0].ram_read),  0);
        step(1);
        check("both done",      32'(g_blk[0].done),      1);
        check("both ram_read2", 32'(g_blk[0].ram_read),  0);
        step(1);
        check("both memory",    g_blk[0].ram_mem[5],     32'hDEAD_BEEF);

        // Same-edge MAR load + read, then mar_in during the transaction
        apply(0, 32'd1, 1, 0, 1, 0);
        check("frz addr read",  32'(g_blk[0].ram_addr), 1);
        apply(0, 32'd7, 1, 0, 0, 0);
        check("frz addr wait",  32'(g_blk[0].ram_addr), 1);
        step(1);
        check("frz addr done",  32'(g_blk[0].ram_addr), 1);
        check("frz mdr_out",    g_blk[0].mdr_out,       42);
        step(1);
        check("frz addr idle",  32'(g_blk[0].ram_addr), 1);
        apply(0, 32'd7, 1, 0, 0, 0);
        check("frz addr load",  32'(g_blk[0].ram_addr), 7);

        // Reset pulse during WAIT
        apply(0, 32'd1, 1, 0, 0, 0);
        apply(0, 32'd0, 0, 0, 1, 0);
        @(posedge clk);
        #2;
        clr_n[0] = 1'b0;
        #1;
        check("abort busy",     32'(g_blk[0].busy),     0);
        check("abort ram_read", 32'(g_blk[0].ram_read), 0);
        check("abort mdr_out",  g_blk[0].mdr_out,       0);
        check("abort ram_addr", 32'(g_blk[0].ram_addr), 0);
        @(posedge clk);
        #1;
        check("abort no done",  32'(g_blk[0].done),     0);
        #2;
        clr_n[0] = 1'b1;
        step(1);
        apply(0, 32'd1, 1, 0, 1, 0);
        step(2);
        check("post-abort done", 32'(g_blk[0].done),    1);
        check("post-abort mdr",  g_blk[0].mdr_out,      42);
        step(1);

        // RD_LAT=3 instance, address 511 (upper bus bits ignored)
        apply(1, 32'hABCD_01FF, 1, 0, 0, 0);
        apply(1, 32'd0, 0, 0, 1, 0);
        k = 1;
        while (!g_blk[1].done && k < 20) begin
            step(1);
            k++;
        end
        check("lat3 done cycle", 32'(k),                 5);
        check("lat3 mdr_out",    g_blk[1].mdr_out,       32'h1234_5678);
        check("lat3 ram_addr",   32'(g_blk[1].ram_addr), 511);
        step(1);

        // Randomized traffic on both instances with rare async resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                b = $urandom;
                if ($urandom_range(0, 1) == 1) b[8:0] = 9'($urandom_range(0, 15));
                bus_in[i] = b;
                mar_in[i] = ($urandom_range(0, 3) == 0);
                mdr_in[i] = ($urandom_range(0, 3) == 0);
                rd_req[i] = ($urandom_range(0, 4) == 0);
                wr_req[i] = ($urandom_range(0, 5) == 0);
                clr_n[i]  = ($urandom_range(0, 199) != 0);
            end
            step(1);
        end
        for (int i = 0; i < 2; i++) begin
            clr_n[i]  = 1'b1;
            mar_in[i] = 1'b0;
            mdr_in[i] = 1'b0;
            rd_req[i] = 1'b0;
            wr_req[i] = 1'b0;
        end
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
